// File: rtl/bin2bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD converter.
// Overflow saturation is enabled by defining BIN2BCD_CONV_OVF_EN.
package bin2bcd_pkg;

    localparam int unsigned BIN_W_DEFAULT = 27;
    localparam int unsigned DIGITS        = 8;
    localparam int unsigned NIBBLES       = DIGITS + 1;
    localparam int unsigned DIG_W         = 4 * DIGITS;
    localparam int unsigned ACC_W         = 4 * NIBBLES;

    localparam logic [31:0]      MAX_VAL = 32'd99_999_999;
    localparam logic [DIG_W-1:0] SAT_DIG = 32'h9999_9999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/bin2bcd_conv_if.sv
// Request/result bundle between a requester and the binary-to-BCD converter.
interface bin2bcd_conv_if
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W = BIN_W_DEFAULT
);

    logic [BIN_W-1:0] iBIN;
    logic             iSTART;
    logic             oBUSY;
    logic             oDONE;
    logic [DIG_W-1:0] oDIG;
    logic             oOVF;

    modport master (
        output iBIN,
        output iSTART,
        input  oBUSY,
        input  oDONE,
        input  oDIG,
        input  oOVF
    );

    modport slave (
        input  iBIN,
        input  iSTART,
        output oBUSY,
        output oDONE,
        output oDIG,
        output oOVF
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o_c
);

    assign nib_o_c = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_CONV_OVF_EN to saturate oDIG and flag oOVF above 99_999_999.
module bin2bcd_conv
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W = BIN_W_DEFAULT
) (
    input  logic           iCLK,
    input  logic           iRST,
    bin2bcd_conv_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [BIN_W-1:0] sr_q,    sr_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [DIG_W-1:0] dig_q,   dig_d;
    logic             ovf_q,   ovf_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    logic [ACC_W-1:0] acc_adj_c;
    logic             unused_acc_msb;

    // Nine corrected nibbles; the ninth keeps carries for values above 10^8.
    for (genvar i = 0; i < NIBBLES; i++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i   (acc_q[4*i +: 4]),
            .nib_o_c (acc_adj_c[4*i +: 4])
        );
    end

    // Top bit is shifted out; it can never be set for BIN_W <= 27.
    assign unused_acc_msb = acc_adj_c[ACC_W-1];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.iSTART) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        acc_d  = acc_q;
        dig_d  = dig_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.iSTART) begin
                    sr_d  = bus.iBIN;
                    acc_d = '0;
                    cnt_d = CNT_W'(BIN_W);
                end
            end
            SHIFT: begin
                acc_d = {acc_adj_c[ACC_W-2:0], sr_q[BIN_W-1]};
                sr_d  = sr_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
            end
            DONE: begin
                done_d = 1'b1;
`ifdef BIN2BCD_CONV_OVF_EN
                if (acc_q[ACC_W-1 -: 4] != 4'd0) begin
                    dig_d = SAT_DIG;
                    ovf_d = 1'b1;
                end else begin
                    dig_d = acc_q[DIG_W-1:0];
                    ovf_d = 1'b0;
                end
`else
                dig_d = acc_q[DIG_W-1:0];
                ovf_d = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            acc_q  <= '0;
            dig_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            dig_q  <= dig_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign bus.oBUSY = busy_q;
    assign bus.oDONE = done_q;
    assign bus.oDIG  = dig_q;
    assign bus.oOVF  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed, table-driven bench for bin2bcd_conv (honours BIN2BCD_CONV_OVF_EN).
module tb_bin2bcd_conv;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] dig;
        logic        ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bin2bcd_conv_if #(.BIN_W(27)) bus ();

    bin2bcd_conv #(.BIN_W(27)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input logic [26:0] v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = 32'(v);
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [26:0] bb_val(input int c);
        return 27'(c * 1000003 + 5);
    endfunction

    // One request pulse, then scramble iBIN; returns edges to oDONE and busy samples.
    task automatic run_conv(input logic [26:0] val, input logic [26:0] junk,
                            output int lat, output int busy_n);
        bus.iBIN   = val;
        bus.iSTART = 1'b1;
        @(posedge clk);
        #1;
        bus.iSTART = 1'b0;
        bus.iBIN   = junk;
        lat    = 0;
        busy_n = bus.oBUSY ? 1 : 0;
        while (!bus.oDONE && lat < 100) begin
            tick();
            lat++;
            if (bus.oBUSY) busy_n++;
        end
    endtask

    vec_t vecs[10];

    initial begin
        int          lat;
        int          busy_n;
        int          n_done;
        logic        seen;
        logic [31:0] held;

        errors     = 0;
        checks     = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        bus.iSTART = 1'b0;
        bus.iBIN   = '0;

        vecs[0] = '{27'd12_345_678, 32'h1234_5678, 1'b0};
        vecs[1] = '{27'd0,          32'h0000_0000, 1'b0};
        vecs[2] = '{27'd1,          32'h0000_0001, 1'b0};
        vecs[3] = '{27'd99_999_999, 32'h9999_9999, 1'b0};
        vecs[4] = '{27'd9,          32'h0000_0009, 1'b0};
        vecs[5] = '{27'd10,         32'h0000_0010, 1'b0};
        vecs[6] = '{27'd50_000_000, 32'h5000_0000, 1'b0};
`ifdef BIN2BCD_CONV_OVF_EN
        vecs[7] = '{27'd100_000_000, 32'h9999_9999, 1'b1};
        vecs[8] = '{27'd5,           32'h0000_0005, 1'b0};
        vecs[9] = '{27'd134_217_727, 32'h9999_9999, 1'b1};
`else
        vecs[7] = '{27'd100_000_000, 32'h0000_0000, 1'b0};
        vecs[8] = '{27'd5,           32'h0000_0005, 1'b0};
        vecs[9] = '{27'd134_217_727, 32'h3421_7727, 1'b0};
`endif

        repeat (2) tick();
        check("rst_busy", 32'(bus.oBUSY), 32'd0);
        check("rst_done", 32'(bus.oDONE), 32'd0);
        check("rst_dig",  bus.oDIG,       32'd0);
        check("rst_ovf",  32'(bus.oOVF),  32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].bin, 27'h5A5_A5A5 ^ 27'(i), lat, busy_n);
            check("vec_latency", 32'(lat),       32'd28);
            check("vec_busy",    32'(busy_n),    32'd28);
            check("vec_dig",     bus.oDIG,       vecs[i].dig);
            check("vec_ovf",     32'(bus.oOVF),  32'(vecs[i].ovf));
            held = bus.oDIG;
            tick();
            check("vec_done_pulse", 32'(bus.oDONE), 32'd0);
            check("vec_dig_hold",   bus.oDIG,       held);
        end

        // iSTART held high while iBIN changes every cycle.
        bus.iSTART = 1'b1;
        n_done     = 0;
        for (int c = 0; c < 90; c++) begin
            bus.iBIN = bb_val(c);
            @(posedge clk);
            #1;
            if (bus.oDONE) begin
                n_done++;
                check("bb_slot", 32'(c >= 28 && ((c - 28) % 29) == 0), 32'd1);
                check("bb_dig",  bus.oDIG, to_bcd(bb_val(c - 28)));
                check("bb_ovf",  32'(bus.oOVF), 32'd0);
            end
        end
        bus.iSTART = 1'b0;
        check("bb_count", 32'(n_done), 32'd3);
        for (int k = 0; k < 40 && bus.oBUSY; k++) tick();
        check("bb_drain", 32'(bus.oBUSY), 32'd0);

        // Reset ten cycles into a conversion.
        bus.iBIN   = 27'd12_345_678;
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.oBUSY), 32'd0);
        check("abort_dig",  bus.oDIG,       32'd0);
        check("abort_done", 32'(bus.oDONE), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.oDONE) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_conv(27'd7, 27'd99, lat, busy_n);
        check("post_abort_lat", 32'(lat),  32'd28);
        check("post_abort_dig", bus.oDIG,  32'h0000_0007);
        tick();

        // Reset wins over a simultaneous start.
        rst        = 1'b1;
        bus.iSTART = 1'b1;
        bus.iBIN   = 27'd99;
        tick();
        rst        = 1'b0;
        bus.iSTART = 1'b0;
        check("prio_busy0", 32'(bus.oBUSY), 32'd0);
        tick();
        check("prio_busy1", 32'(bus.oBUSY), 32'd0);
        check("prio_dig",   bus.oDIG,       32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
